// File: rtl/sudoku_result_writer_pkg.sv
// rtl/sudoku_result_writer_pkg.sv - shared constants, types and helpers for the result writer
// Contents: grid geometry, word/status layout, FSM state encodings, bcd_grid_t, saturating increment.
package sudoku_result_writer_pkg;

  localparam int GRID_N         = 9;
  localparam int NUM_CELLS      = 81;
  localparam int CELLS_PER_WORD = 8;
  localparam int DATA_WORDS     = 11;
  localparam int STATUS_IDX     = 11;
  localparam int NUM_WORDS      = 12;

  // Cause bit positions inside the status word
  localparam int STAT_SOLVED  = 0;
  localparam int STAT_FAIL    = 1;
  localparam int STAT_STALLED = 2;
  localparam int STAT_TIMEOUT = 3;

  typedef logic [1:0] writer_state_t;
  localparam writer_state_t ST_IDLE  = 2'd0;
  localparam writer_state_t ST_WAIT  = 2'd1;
  localparam writer_state_t ST_WRITE = 2'd2;
  localparam writer_state_t ST_FIN   = 2'd3;

  // [row][col] of 4-bit BCD digits, 0 = unresolved
  typedef logic [8:0][8:0][3:0] bcd_grid_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sudoku_result_writer_if.sv
// rtl/sudoku_result_writer_if.sv - control, grid and BRAM write bundle of the result writer
// Signals: start/cells/fail toward the writer; addr_out/din_out/we_out BRAM write port;
// busy/done status. master = writer side, slave = solver/BRAM/controller side.
interface sudoku_result_writer_if;
  import sudoku_result_writer_pkg::*;

  logic        start;
  bcd_grid_t   cells;
  logic        fail;
  logic [31:0] addr_out;
  logic [31:0] din_out;
  logic        we_out;
  logic        busy;
  logic        done;

  modport master (
    input  start, cells, fail,
    output addr_out, din_out, we_out, busy, done
  );

  modport slave (
    output start, cells, fail,
    input  addr_out, din_out, we_out, busy, done
  );

endinterface

// File: rtl/sudoku_result_writer_cell_word_packer.sv
// rtl/sudoku_result_writer_cell_word_packer.sv - packs eight BCD cells of a grid into one 32-bit word
// Ports: grid (in, bcd_grid_t), word_idx (in, 4b), word (out, 32b; nibble i = cell 8*word_idx+i,
// cells past the end of the grid read as 0).
module sudoku_result_writer_cell_word_packer
  import sudoku_result_writer_pkg::*;
#(
  parameter int WIDTH = GRID_N
) (
  input  bcd_grid_t   grid,
  input  logic [3:0]  word_idx,
  output logic [31:0] word
);

  localparam int CELLS = WIDTH * WIDTH;

  // Row-major packing puts cell n at bits [4n+3:4n] of the flattened grid
  logic [323:0] flat;
  logic [6:0]   cell_n;

  assign flat = grid;

  always_comb begin
    word   = '0;
    cell_n = '0;
    for (int i = 0; i < CELLS_PER_WORD; i++) begin
      cell_n = {word_idx, 3'(i)};
      if (cell_n < 7'(CELLS)) begin
        word[4*i +: 4] = flat[{cell_n, 2'b00} +: 4];
      end
    end
  end

endmodule

// File: rtl/sudoku_result_writer.sv
// rtl/sudoku_result_writer.sv - drains the solver result grid plus a status word into output BRAM
// Ports: clk, reset_L (async, active-low), bus (sudoku_result_writer_if.master):
// start/cells/fail in; addr_out/din_out/we_out BRAM write port, busy, done out.
module sudoku_result_writer
  import sudoku_result_writer_pkg::*;
#(
  parameter int          WIDTH        = 9,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          STALL_CYCLES = 4,
  parameter int          TIMEOUT      = 1023
) (
  input logic                    clk,
  input logic                    reset_L,
  sudoku_result_writer_if.master bus
);

  writer_state_t state;
  bcd_grid_t     prev_grid;
  bcd_grid_t     snap_grid;
  logic [15:0]   stall_cnt;
  logic [15:0]   cyc_cnt;
  logic [3:0]    cause;
  logic [3:0]    idx;
  logic [31:0]   addr_q;
  logic [31:0]   din_q;
  logic          we_q;
  logic          done_q;

  logic          solved;
  logic          stalled;
  logic          timed_out;
  logic [15:0]   stall_nxt;
  logic [15:0]   cyc_nxt;
  logic [3:0]    cause_nxt;
  logic [31:0]   packed_word;
  logic [31:0]   status_word;

  always_comb begin
    solved = 1'b1;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        if (bus.cells[r][c] == 4'd0) solved = 1'b0;
      end
    end
  end

  // Both counters include the cycle being evaluated, so a solved grid seen on
  // the first WAIT cycle reports cyc_cnt = 1 and TIMEOUT counts WAIT cycles.
  assign stall_nxt = (bus.cells == prev_grid) ? sat_inc16(stall_cnt) : 16'd0;
  assign cyc_nxt   = sat_inc16(cyc_cnt);
  assign stalled   = (stall_nxt >= 16'(STALL_CYCLES));
  assign timed_out = (cyc_nxt == 16'(TIMEOUT));

  // Only the highest-priority cause is recorded
  always_comb begin
    cause_nxt = '0;
    if (solved)         cause_nxt[STAT_SOLVED]  = 1'b1;
    else if (bus.fail)  cause_nxt[STAT_FAIL]    = 1'b1;
    else if (stalled)   cause_nxt[STAT_STALLED] = 1'b1;
    else if (timed_out) cause_nxt[STAT_TIMEOUT] = 1'b1;
  end

  assign status_word = {cyc_cnt, 12'd0, cause};

  sudoku_result_writer_cell_word_packer #(
    .WIDTH (WIDTH)
  ) u_packer (
    .grid     (snap_grid),
    .word_idx (idx),
    .word     (packed_word)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_IDLE;
      prev_grid <= '0;
      snap_grid <= '0;
      stall_cnt <= '0;
      cyc_cnt   <= '0;
      cause     <= '0;
      idx       <= '0;
      addr_q    <= BASE_ADDR;
      din_q     <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_WAIT;
            stall_cnt <= '0;
            cyc_cnt   <= '0;
            prev_grid <= '0;
          end
        end
        ST_WAIT: begin
          prev_grid <= bus.cells;
          stall_cnt <= stall_nxt;
          cyc_cnt   <= cyc_nxt;
          if (cause_nxt != 4'd0) begin
            snap_grid <= bus.cells;
            cause     <= cause_nxt;
            idx       <= '0;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Writes trail idx by one register stage; the pass with idx at
          // NUM_WORDS retires the final word and raises done.
          if (idx == 4'(NUM_WORDS)) begin
            done_q <= 1'b1;
            state  <= ST_FIN;
          end else begin
            we_q   <= 1'b1;
            addr_q <= BASE_ADDR + {26'd0, idx, 2'b00};
            din_q  <= (idx == 4'(STATUS_IDX)) ? status_word : packed_word;
            idx    <= idx + 4'd1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.addr_out = addr_q;
  assign bus.din_out  = din_q;
  assign bus.we_out   = we_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state != ST_IDLE);

endmodule
